// File: rtl/dds_seq_pkg.sv
// Shared types and constants for the DDS waveform sequencer.
package dds_seq_pkg;

    localparam int unsigned FWORD_W   = 32;
    localparam int unsigned DWELL_W   = 16;
    localparam int unsigned NUM_STEPS = 4;
    localparam int unsigned IDX_W     = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        WAIT_WRAP = 2'd2
    } seq_state_t;

    localparam logic [1:0] WAVE_COS    = 2'd0;
    localparam logic [1:0] WAVE_SIN    = 2'd1;
    localparam logic [1:0] WAVE_SQUARE = 2'd2;
    localparam logic [1:0] WAVE_TRI    = 2'd3;

    typedef struct packed {
        logic [1:0]         sel;
        logic [FWORD_W-1:0] fword;
        logic [DWELL_W-1:0] dwell;
        logic               last;
    } step_t;

    // Reset value of a table entry: cosine, zero increment, one cycle, final step.
    function automatic step_t default_step();
        step_t s;
        s.sel   = WAVE_COS;
        s.fword = '0;
        s.dwell = '0;
        s.last  = 1'b1;
        return s;
    endfunction

endpackage

// File: rtl/dds_seq_dwell_timer.sv
// Per-step dwell counter: load a value, count down to zero and hold there.
module dds_seq_dwell_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero_c
);

    logic [W-1:0] count;

    // Load takes priority over decrement; the count never wraps below zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/dds_wave_sequencer.sv
// DDS waveform/frequency sequencer: steps through a 4-entry table of
// {waveform, phase increment, dwell, last}. Optional macro SEQ_PHASE_SYNC_EN
// defers each step change to the next accumulator wrap for phase continuity.
module dds_wave_sequencer
    import dds_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [1:0]         cfg_idx,
    input  logic [1:0]         cfg_sel,
    input  logic [FWORD_W-1:0] cfg_fword,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_last,
    input  logic               start,
    input  logic               stop,
    input  logic               loop_en,
    input  logic               phase_wrap,
    output logic [1:0]         mux,
    output logic [FWORD_W-1:0] fword,
    output logic               phase_clr,
    output logic [1:0]         step_idx,
    output logic               busy,
    output logic               done
);

    seq_state_t         state;
    step_t              tbl [NUM_STEPS];

    logic               tmr_zero_c;
    logic               cfg_we_c;
    logic               go_c;
    logic               step_end_c;
    logic               finish_c;
    logic               advance_c;
    logic               cur_last_c;
    logic [IDX_W-1:0]   nxt_idx_c;
    logic [IDX_W-1:0]   ld_idx_c;
    logic [1:0]         ld_sel_c;
    logic [FWORD_W-1:0] ld_fword_c;
    logic [DWELL_W-1:0] ld_dwell_c;

    // Config is only accepted while idle so the table is frozen during a run.
    assign cfg_ready = (state == IDLE);
    assign cfg_we_c  = cfg_valid && cfg_ready;
    assign go_c      = (state == IDLE) && start && !stop;

`ifdef SEQ_PHASE_SYNC_EN
    // Step boundaries wait for the accumulator wrap; stop always wins.
    assign step_end_c = (state == WAIT_WRAP) && phase_wrap && !stop;
`else
    // Step boundaries occur directly on dwell expiry; phase_wrap is not used.
    assign step_end_c = (state == RUN) && tmr_zero_c && !stop;
    logic unused_phase_wrap;
    assign unused_phase_wrap = phase_wrap;
`endif

    // Next entry: sequential, back to 0 after the last entry, 2-bit wrap after 3.
    assign cur_last_c = tbl[step_idx].last;
    assign finish_c   = step_end_c && cur_last_c && !loop_en;
    assign advance_c  = step_end_c && !finish_c;
    assign nxt_idx_c  = cur_last_c ? '0 : (step_idx + IDX_W'(1));
    assign ld_idx_c   = go_c ? '0 : nxt_idx_c;
    assign ld_sel_c   = tbl[ld_idx_c].sel;
    assign ld_fword_c = tbl[ld_idx_c].fword;
    assign ld_dwell_c = tbl[ld_idx_c].dwell;

    // Dwell timer reloads on every step entry and counts only while running.
    dds_seq_dwell_timer #(
        .W (DWELL_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (go_c || advance_c),
        .load_val (ld_dwell_c),
        .dec      (state == RUN),
        .zero_c   (tmr_zero_c)
    );

    // Step table: cleared on reset, written one full entry per accepted config beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_STEPS); i++) begin
                tbl[i] <= default_step();
            end
        end else if (cfg_we_c) begin
            tbl[cfg_idx] <= '{sel: cfg_sel, fword: cfg_fword, dwell: cfg_dwell, last: cfg_last};
        end
    end

    // Sequencer FSM with registered DDS controls; outputs hold across stop/done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mux       <= '0;
            fword     <= '0;
            phase_clr <= 1'b0;
            step_idx  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            phase_clr <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (go_c) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        phase_clr <= 1'b1;
                        mux       <= ld_sel_c;
                        fword     <= ld_fword_c;
                        step_idx  <= '0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
`ifdef SEQ_PHASE_SYNC_EN
                    end else if (tmr_zero_c) begin
                        state <= WAIT_WRAP;
`endif
                    end
                end
                WAIT_WRAP: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Step boundary: either finish the run or load the next entry seamlessly.
            if (finish_c) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
            end else if (advance_c) begin
                state    <= RUN;
                mux      <= ld_sel_c;
                fword    <= ld_fword_c;
                step_idx <= ld_idx_c;
            end
        end
    end

endmodule

// File: doc/dds_wave_sequencer.md
Name: dds_wave_sequencer

Overview:
- Programmable controller that sequences the DDS output waveform mux and the phase-increment (frequency) word through a table of up to 4 steps.
- Each step holds a waveform select, a frequency word and a dwell time.
- Sits between the register/config interface and the DDS core: drives the 2-bit waveform select (cos=0, sin=1, square=2, triangular=3) and the phase accumulator's increment and clear.

Parameters:
- FWORD_W, 32, width of the phase-increment word.
- DWELL_W, 16, width of the per-step dwell counter.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  table write request
- cfg_ready  out  1  table write accepted when high; high only in IDLE
- cfg_idx  in  2  table entry to write
- cfg_sel  in  2  waveform select for the entry
- cfg_fword  in  FWORD_W  phase increment for the entry
- cfg_dwell  in  DWELL_W  dwell for the entry; step lasts cfg_dwell+1 cycles
- cfg_last  in  1  entry is the final step of the sequence
- start  in  1  begin the sequence at entry 0 (IDLE only)
- stop  in  1  abort the sequence
- loop_en  in  1  after the last step, restart at entry 0 instead of finishing
- phase_wrap  in  1  accumulator overflow pulse from the DDS; used only with SEQ_PHASE_SYNC_EN
- mux  out  2  waveform select to the DDS output mux
- fword  out  FWORD_W  phase increment to the accumulator
- phase_clr  out  1  one-cycle accumulator clear
- step_idx  out  2  currently active entry
- busy  out  1  sequence running
- done  out  1  one-cycle pulse on natural completion

Behaviour:
- Reset (synchronous):
  - state IDLE; mux=0, fword=0, phase_clr=0, step_idx=0, busy=0, done=0; cfg_ready=1 (decoded from IDLE).
  - All table entries cleared to sel=0, fword=0, dwell=0, last=1.
  - A reset mid-sequence takes effect at that edge, discarding the run and the table.
- Config write:
  - Fires on cfg_valid & cfg_ready at the rising edge and writes all fields of entry cfg_idx.
  - Writes during RUN are not accepted (cfg_ready=0); the table is stable while running.
- FSM states: IDLE, RUN, plus WAIT_WRAP with the macro.
- IDLE → RUN on start:
  - At the edge where start=1: mux/fword load entry 0, step_idx=0, busy=1, phase_clr=1 for exactly that next cycle.
  - Dwell counter loads entry 0's dwell. Latency start→outputs is 1 cycle.
  - start while busy is ignored.
- RUN:
  - Counter decrements each cycle. When the counter is 0 at an edge, the step ends; a step with dwell=D is visible for D+1 cycles.
  - Step end on a non-last entry: load entry step_idx+1 (outputs and counter) at the same edge; no phase_clr; no gap cycle.
  - Step end on a last entry with loop_en=1: load entry 0; no phase_clr.
  - Step end on a last entry with loop_en=0: done=1 for one cycle, busy=0, go to IDLE. mux/fword/step_idx hold their final values.
  - Entry 3 with last=0 wraps to entry 0 (2-bit index wrap).
- stop:
  - In RUN or WAIT_WRAP: next edge → IDLE, busy=0, done=0; outputs hold.
  - stop has priority over step expiry and over phase_wrap in the same cycle.
  - stop and start in the same cycle in IDLE: stay IDLE.
- phase_clr is asserted only on start, never on step transitions.

Optional Feature:
- SEQ_PHASE_SYNC_EN defined:
  - Counter reaching 0 moves RUN → WAIT_WRAP; outputs and step_idx hold.
  - The step transition (next entry, loop, or done/IDLE) occurs at the first edge with phase_wrap=1, including the edge immediately after entering WAIT_WRAP.
  - phase_wrap in RUN is ignored. This gives phase-continuous waveform switching.
- SEQ_PHASE_SYNC_EN undefined: no WAIT_WRAP state; phase_wrap is unconnected internally; transitions occur on counter expiry exactly as described above.

Decomposition:
- Package dds_seq_pkg holds:
  - state encoding: IDLE, RUN, WAIT_WRAP;
  - waveform select constants: WAVE_COS=2'd0, WAVE_SIN=2'd1, WAVE_SQUARE=2'd2, WAVE_TRI=2'd3;
  - step-entry struct: sel, fword, dwell, last.
- One sub-module, dds_seq_dwell_timer: load/decrement counter with a zero flag. The table and FSM stay in the top.

Test Plan:
- Reset then idle → all outputs 0, cfg_ready=1. start with the default table → entry 0 active for 1 cycle, phase_clr for 1 cycle, done pulses on the 2nd cycle after start.
- Program entries 0..2 as (COS, 0x100, dwell 3, last 0), (SQUARE, 0x200, dwell 0, last 0), (TRI, 0x40, dwell 1, last 1), loop_en=0 → mux sequence 0,0,0,0,2,3,3; done pulses with mux=3 held; busy=0.
- Same table, loop_en=1 → after TRI's 2 cycles, returns to COS/0x100 with no phase_clr; runs until stop, then IDLE next edge, done stays 0.
- stop asserted on the exact expiry cycle of entry 0 → IDLE, step_idx stays 0, no done. cfg_valid during RUN → cfg_ready=0 and the table is unchanged on readback by rerun.
- Synchronous reset asserted mid-RUN → next cycle all outputs 0 and the table cleared (rerun shows default behaviour).
- With SEQ_PHASE_SYNC_EN: entry 0 dwell 0, phase_wrap asserted 5 cycles late → mux holds entry 0 until the phase_wrap edge, then entry 1. phase_wrap coincident with stop → IDLE.
